// File: rtl/vc_demux_fifo_pair.sv
// Steers words popped from the main FIFO into two virtual-channel FIFOs by one
// class bit, and serves independent per-VC pops with registered outputs.

module vc_demux_fifo_ch #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_valid,
    output logic                  o_pause,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_error
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]         AF_CNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid;
    logic                  r_error;

    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_wr_ok;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_rd_ok = i_pop & ~w_empty;
    // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
    assign w_wr_ok = i_wr & (~w_full | w_rd_ok);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if ((i_wr & ~w_wr_ok) | (i_pop & w_empty)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_dout  = r_dout;
    assign o_valid = r_valid;
    assign o_count = r_count;
    assign o_error = r_error;
    assign o_empty = w_empty;
    assign o_pause = (r_count >= AF_CNT);
endmodule

module vc_demux_fifo_pair #(
    parameter int DATA_WIDTH = 6,
    parameter int VC_SEL_BIT = 5,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  pop_vc0,
    input  logic                  pop_vc1,
    output logic [DATA_WIDTH-1:0] data_out_vc0,
    output logic [DATA_WIDTH-1:0] data_out_vc1,
    output logic                  valid_out_vc0,
    output logic                  valid_out_vc1,
    output logic                  pause_vc0,
    output logic                  pause_vc1,
    output logic                  empty_vc0,
    output logic                  empty_vc1,
    output logic [ADDR_WIDTH:0]   count_vc0,
    output logic [ADDR_WIDTH:0]   count_vc1,
    output logic                  error_vc0,
    output logic                  error_vc1
);
    logic w_to_vc1;
    logic w_wr_vc0;
    logic w_wr_vc1;

    assign w_to_vc1 = data_in[VC_SEL_BIT];
    assign w_wr_vc0 = valid_in & ~w_to_vc1;
    assign w_wr_vc1 = valid_in & w_to_vc1;

    vc_demux_fifo_ch #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .AF_THRESH (AF_THRESH)
    ) u_vc0 (
        .clk    (clk),
        .reset_L(reset_L),
        .i_wr   (w_wr_vc0),
        .i_din  (data_in),
        .i_pop  (pop_vc0),
        .o_dout (data_out_vc0),
        .o_valid(valid_out_vc0),
        .o_pause(pause_vc0),
        .o_empty(empty_vc0),
        .o_count(count_vc0),
        .o_error(error_vc0)
    );

    vc_demux_fifo_ch #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .AF_THRESH (AF_THRESH)
    ) u_vc1 (
        .clk    (clk),
        .reset_L(reset_L),
        .i_wr   (w_wr_vc1),
        .i_din  (data_in),
        .i_pop  (pop_vc1),
        .o_dout (data_out_vc1),
        .o_valid(valid_out_vc1),
        .o_pause(pause_vc1),
        .o_empty(empty_vc1),
        .o_count(count_vc1),
        .o_error(error_vc1)
    );
endmodule

// File: tb/tb_vc_demux_fifo_pair.sv
// Scoreboard bench for vc_demux_fifo_pair: directed scenarios plus random
// traffic, checked against a queue-based model of the two virtual channels.

module tb_vc_demux_fifo_pair;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [5:0] data_in = '0;
    logic       valid_in = 1'b0;
    logic       pop_vc0 = 1'b0;
    logic       pop_vc1 = 1'b0;
    logic [5:0] data_out_vc0, data_out_vc1;
    logic       valid_out_vc0, valid_out_vc1;
    logic       pause_vc0, pause_vc1;
    logic       empty_vc0, empty_vc1;
    logic [4:0] count_vc0, count_vc1;
    logic       error_vc0, error_vc1;

    int compared = 0;
    int mismatched = 0;

    // Model: contents of each VC as a plain queue, plus expected read responses.
    logic [5:0] mq   [2][$];
    logic [5:0] expq [2][$];
    logic [5:0] mdout [2];
    logic       mvout [2];
    logic       merr  [2];

    vc_demux_fifo_pair #(
        .DATA_WIDTH(6),
        .VC_SEL_BIT(5),
        .ADDR_WIDTH(4),
        .AF_THRESH (AF)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .pop_vc0      (pop_vc0),
        .pop_vc1      (pop_vc1),
        .data_out_vc0 (data_out_vc0),
        .data_out_vc1 (data_out_vc1),
        .valid_out_vc0(valid_out_vc0),
        .valid_out_vc1(valid_out_vc1),
        .pause_vc0    (pause_vc0),
        .pause_vc1    (pause_vc1),
        .empty_vc0    (empty_vc0),
        .empty_vc1    (empty_vc1),
        .count_vc0    (count_vc0),
        .count_vc1    (count_vc1),
        .error_vc0    (error_vc0),
        .error_vc1    (error_vc1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < 2; v++) begin
            mq[v].delete();
            expq[v].delete();
            mdout[v] = '0;
            mvout[v] = 1'b0;
            merr[v]  = 1'b0;
        end
    endtask

    // Effect of one clock edge: each VC serves its read first, then its write.
    task automatic model_edge(input logic vin, input logic [5:0] din,
                              input logic p0, input logic p1);
        for (int v = 0; v < 2; v++) begin
            logic rd;
            logic wr;
            logic [5:0] w;
            rd = (v == 0) ? p0 : p1;
            wr = vin && (int'(din[5]) == v);
            mvout[v] = 1'b0;
            if (rd) begin
                if (mq[v].size() == 0) begin
                    merr[v] = 1'b1;
                end else begin
                    w = mq[v].pop_front();
                    expq[v].push_back(w);
                    mdout[v] = w;
                    mvout[v] = 1'b1;
                end
            end
            if (wr) begin
                if (mq[v].size() >= DEPTH) merr[v] = 1'b1;
                else mq[v].push_back(din);
            end
        end
    endtask

    task automatic cyc(input logic vin, input logic [5:0] din, input logic p0, input logic p1);
        @(negedge clk);
        valid_in = vin;
        data_in  = din;
        pop_vc0  = p0;
        pop_vc1  = p1;
        if (reset_L) model_edge(vin, din, p0, p1);
        else begin
            mvout[0] = 1'b0;
            mvout[1] = 1'b0;
        end
    endtask

    task automatic check_vc(input int v, input logic [4:0] cnt, input logic emp,
                            input logic pau, input logic err, input logic vout,
                            input logic [5:0] dout);
        int sz;
        logic [5:0] e;
        sz = mq[v].size();
        chk($sformatf("vc%0d_count", v), 32'(cnt), 32'(sz));
        chk($sformatf("vc%0d_empty", v), 32'(emp), 32'(sz == 0));
        chk($sformatf("vc%0d_pause", v), 32'(pau), 32'(sz >= AF));
        chk($sformatf("vc%0d_error", v), 32'(err), 32'(merr[v]));
        chk($sformatf("vc%0d_valid", v), 32'(vout), 32'(mvout[v]));
        if (vout === 1'b1) begin
            if (expq[v].size() == 0) begin
                chk($sformatf("vc%0d_unexpected_valid", v), 32'(1), 32'(0));
            end else begin
                e = expq[v].pop_front();
                chk($sformatf("vc%0d_data", v), 32'(dout), 32'(e));
            end
        end else begin
            chk($sformatf("vc%0d_data_hold", v), 32'(dout), 32'(mdout[v]));
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            check_vc(0, count_vc0, empty_vc0, pause_vc0, error_vc0, valid_out_vc0, data_out_vc0);
            check_vc(1, count_vc1, empty_vc1, pause_vc1, error_vc1, valid_out_vc1, data_out_vc1);
        end
    end

    initial begin : driver
        logic [5:0] d;
        model_clear();
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        reset_L = 1'b1;
        repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);

        // Steering by the class bit, then a simultaneous pop on both VCs.
        cyc(1'b1, 6'b000011, 1'b0, 1'b0);
        cyc(1'b1, 6'b100101, 1'b0, 1'b0);
        cyc(1'b1, 6'h00, 1'b1, 1'b1) ;
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // VC0 past the almost-full threshold by one word, then drain in order.
        for (int i = 0; i < 13; i++) cyc(1'b1, 6'(i), 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // VC1 overflow, then pointer wrap with pops and writes.
        for (int i = 0; i < 16; i++) cyc(1'b1, 6'h20 | 6'(i), 1'b0, 1'b0);
        cyc(1'b1, 6'h3F, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 6'h30 + 6'(i), 1'b0, 1'b0);
        cyc(1'b1, 6'h2A, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) cyc(1'b0, '0, 1'b0, 1'b1);

        // VC0 simultaneous push/pop at count 5, drain, then underflow on empty.
        for (int i = 0; i < 5; i++) cyc(1'b1, 6'h10 + 6'(i), 1'b0, 1'b0);
        cyc(1'b1, 6'h1A, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Random traffic, loosely honouring pause upstream.
        for (int n = 0; n < 3000; n++) begin
            logic vin;
            d   = 6'($urandom);
            vin = ($urandom_range(0, 3) != 0);
            if ((pause_vc0 || pause_vc1) && $urandom_range(0, 3) != 0) vin = 1'b0;
            cyc(vin, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Async reset mid-stream with count_vc0=7 and valid_out_vc0=1.
        cyc(1'b0, '0, 1'b1, 1'b1);
        while (mq[0].size() > 0 || mq[1].size() > 0) cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 6'h08 + 6'(i), 1'b0, 1'b0);
        cyc(1'b1, 6'h0F, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        chk("pre_reset_vc0_valid", 32'(valid_out_vc0), 32'(1));
        chk("pre_reset_vc0_count", 32'(count_vc0), 32'(7));
        reset_L = 1'b0;
        #1;
        chk("async_reset_vc0_valid", 32'(valid_out_vc0), 32'(0));
        chk("async_reset_vc0_count", 32'(count_vc0), 32'(0));
        chk("async_reset_vc0_data", 32'(data_out_vc0), 32'(0));
        chk("async_reset_vc0_empty", 32'(empty_vc0), 32'(1));
        chk("async_reset_vc1_error", 32'(error_vc1), 32'(0));
        model_clear();
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        reset_L  = 1'b1;
        valid_in = 1'b1;
        data_in  = 6'h07;
        pop_vc0  = 1'b0;
        pop_vc1  = 1'b0;
        model_edge(1'b1, 6'h07, 1'b0, 1'b0);
        cyc(1'b1, 6'h27, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);

        chk("vc0_leftover_expected", 32'(expq[0].size()), 32'(0));
        chk("vc1_leftover_expected", 32'(expq[1].size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/vc_demux_fifo_pair.md
Name: vc_demux_fifo_pair

Overview:
- Downstream stage of the main-FIFO pop/valid logic.
- Takes each word popped from the main FIFO and steers it, by one class bit, into one of two virtual-channel FIFOs (VC0, VC1). Each FIFO is DEPTH words deep.
- Generates the pause_vc0/pause_vc1 back-pressure flags that gate main-FIFO popping.
- Serves independent per-VC pop requests from the next stage, with registered data/valid outputs.

Parameters:
- DATA_WIDTH, 6: width of a data word.
- VC_SEL_BIT, 5: bit index of data_in that selects the VC (0 selects VC0, 1 selects VC1).
- ADDR_WIDTH, 4: FIFO address width; DEPTH = 2**ADDR_WIDTH = 16.
- AF_THRESH, 12: almost-full threshold. Legal only if AF_THRESH + 1 <= DEPTH.

Ports:
- clk  input  1  rising-edge clock
- reset_L  input  1  asynchronous, active-low reset
- data_in  input  DATA_WIDTH  word from main FIFO, valid in the cycle after pop_Main
- valid_in  input  1  connected to valid_pop_out; qualifies data_in
- pop_vc0  input  1  downstream read request, VC0
- pop_vc1  input  1  downstream read request, VC1
- data_out_vc0  output  DATA_WIDTH  registered read data, VC0
- data_out_vc1  output  DATA_WIDTH  registered read data, VC1
- valid_out_vc0  output  1  data_out_vc0 is valid this cycle
- valid_out_vc1  output  1  data_out_vc1 is valid this cycle
- pause_vc0  output  1  VC0 almost full
- pause_vc1  output  1  VC1 almost full
- empty_vc0  output  1  VC0 holds no words
- empty_vc1  output  1  VC1 holds no words
- count_vc0  output  ADDR_WIDTH+1  VC0 occupancy, 0..DEPTH
- count_vc1  output  ADDR_WIDTH+1  VC1 occupancy, 0..DEPTH
- error_vc0  output  1  sticky overflow/underflow flag, VC0
- error_vc1  output  1  sticky overflow/underflow flag, VC1

Behaviour:

Reset:
- reset_L=0 asynchronously clears all write/read pointers, counts, data_out_*, valid_out_* and error_*.
- After reset: empty_*=1, pause_*=0.
- Memory contents are don't-care.
- Reset asserted mid-operation discards all stored and in-flight words. A valid_in arriving on the first edge after release is written normally.

Write path:
- On a clk edge with valid_in=1, data_in is written to the FIFO selected by data_in[VC_SEL_BIT], at that FIFO's write pointer. The write pointer then increments modulo DEPTH.
- The full word, including the class bit, is stored.
- Write to a full FIFO (count==DEPTH): word dropped, pointer and count unchanged, error_vcX set.

Read path:
- On a clk edge with pop_vcX=1 and count_vcX>0: data_out_vcX gets mem[rd_ptr], valid_out_vcX=1, and the read pointer increments modulo DEPTH.
- Read latency is one cycle from pop to valid.
- pop_vcX with count_vcX==0: ignored, valid_out_vcX=0, error_vcX set.
- When no read occurs, valid_out_vcX=0 and data_out_vcX holds its last value.

Occupancy:
- count_vcX +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- A simultaneous write and read on an empty FIFO is treated as a read underflow plus a write: count becomes 1, error set. There is no bypass.
- A simultaneous write and read on a full FIFO is treated as read, then write: both succeed, no error.

Flags:
- empty_vcX = (count_vcX==0), combinational from the registered count.
- pause_vcX = (count_vcX >= AF_THRESH), combinational from the registered count.
- Pause headroom: main-FIFO pop is combinational, and the popped word lands one cycle later. So up to one further word can be accepted after pause rises, bounding count at AF_THRESH+1. That is why AF_THRESH+1 <= DEPTH is required.
- error_vcX is sticky until reset.

VC0 and VC1 operate fully independently. Either pause stalls the shared main FIFO; that gating lives in the upstream stage.

Test Plan:
- Reset then idle: reset_L low 3 cycles, then high → all counts 0, empty_vc0=empty_vc1=1, pause_*=0, valid_out_*=0, error_*=0.
- Steering: valid_in with data_in=6'b000011 then 6'b100101 → count_vc0=1 and count_vc1=1. Next, pop_vc0 and pop_vc1 together → one cycle later data_out_vc0=6'h03 and data_out_vc1=6'h25, both valid_out=1.
- Almost full and headroom: 13 consecutive VC0 writes (0x00..0x0C) → pause_vc0 rises when count_vc0 reaches 12, final count 13, error_vc0=0. Draining 13 pops returns 0x00..0x0C in order, empty_vc0=1 at end.
- Overflow and wrap: 16 VC1 writes, then a 17th (0x3F) → count_vc1=16, error_vc1=1, 0x3F never read. Then pop 4 and write 4 (0x30..0x33) → pointer wraps; full drain order is original words 5..16 followed by 0x30..0x33.
- Simultaneous push/pop at count 5 on VC0 → count stays 5, correct FIFO ordering kept. pop_vc0 on an empty VC0 → valid_out_vc0=0, error_vc0=1, count stays 0.
- Async reset mid-stream: reset_L low between edges while count_vc0=7 and valid_out_vc0=1 → outputs clear immediately without waiting for clk, count_vc0=0. Writes after release are stored normally.
